// File: rtl/microseq_ctrl.sv
// -----------------------------------------------------------------------------
// microseq_ctrl
//   Microprogram sequencer for the control unit. It holds the microprogram
//   counter (uPC), drives it onto the control-store address, and decodes the
//   sequencer fields of the fetched microword to pick the next microaddress:
//   increment, jump, conditional jump, IR dispatch, call, return, conditional
//   return, or fetch. Calls and returns use a small LIFO microstack.
//   The whole microword is registered as the control word for the datapath.
//
// Microword layout (CW_W bits):
//   [CW_W-1:CW_W-3] NS   next-address mode
//   [CW_W-4]        INV  invert the selected condition
//   [CW_W-5:CW_W-7] CS   condition select into cond_in
//   [AW-1:0]        CR   branch / call target
//
// Ports:
//   clk        in   1     system clock, rising edge
//   reset      in   1     asynchronous active-high reset
//   rom_addr   out  AW    control store address (the uPC register)
//   rom_data   in   CW_W  microword at rom_addr (combinational store)
//   disp_addr  in   AW    dispatch target from the instruction decoder
//   cond_in    in   8     condition inputs, one selected by CS
//   stall      in   1     hold the sequencer; inserts a NOP control word
//   cw_out     out  CW_W  registered control word for the datapath
//   upc_out    out  AW    current uPC (debug)
//   stk_err    out  1     sticky microstack overflow/underflow flag
// -----------------------------------------------------------------------------
module microseq_ctrl #(
  parameter int CW_W       = 64,
  parameter int AW         = 8,
  parameter int STK_D      = 4,
  parameter int RESET_ADDR = 0,
  parameter int FETCH_ADDR = 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [AW-1:0]   rom_addr,
  input  logic [CW_W-1:0] rom_data,
  input  logic [AW-1:0]   disp_addr,
  input  logic [7:0]      cond_in,
  input  logic            stall,
  output logic [CW_W-1:0] cw_out,
  output logic [AW-1:0]   upc_out,
  output logic            stk_err
);

  // Next-address modes (NS field)
  localparam logic [2:0] NS_INC   = 3'd0;
  localparam logic [2:0] NS_JMP   = 3'd1;
  localparam logic [2:0] NS_CJMP  = 3'd2;
  localparam logic [2:0] NS_DISP  = 3'd3;
  localparam logic [2:0] NS_CALL  = 3'd4;
  localparam logic [2:0] NS_RET   = 3'd5;
  localparam logic [2:0] NS_CRET  = 3'd6;
  localparam logic [2:0] NS_FETCH = 3'd7;

  // Stack pointer must be able to count 0..STK_D inclusive.
  localparam int SPW = $clog2(STK_D + 1);

  localparam logic [AW-1:0]  RST_A   = AW'(RESET_ADDR);
  localparam logic [AW-1:0]  FETCH_A = AW'(FETCH_ADDR);
  localparam logic [AW-1:0]  A_ONE   = AW'(1);
  localparam logic [SPW-1:0] SP_ZERO = SPW'(0);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STK_D);

  // State
  logic [AW-1:0]   upc_r;
  logic [CW_W-1:0] cw_r;
  logic [SPW-1:0]  sp_r;
  logic            stk_err_r;
  // Stack is kept as a shift register: entry 0 is always the top, so no
  // pointer-indexed access is needed.
  logic [AW-1:0]   stack_r [STK_D];

  // Decoded fields and next-state controls
  logic [2:0]    ns_s;
  logic          inv_s;
  logic [2:0]    cs_s;
  logic [AW-1:0] cr_s;
  logic          cond_s;
  logic [AW-1:0] inc_s;
  logic [AW-1:0] next_upc_s;
  logic          push_s;
  logic          pop_s;
  logic          err_set_s;

  assign ns_s   = rom_data[CW_W-1 -: 3];
  assign inv_s  = rom_data[CW_W-4];
  assign cs_s   = rom_data[CW_W-5 -: 3];
  assign cr_s   = rom_data[AW-1:0];
  assign cond_s = cond_in[cs_s] ^ inv_s;
  // Natural AW-bit wrap from all-ones back to zero.
  assign inc_s  = upc_r + A_ONE;

  // Next microaddress selection and stack push/pop/error requests
  always_comb begin
    next_upc_s = inc_s;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    err_set_s  = 1'b0;
    case (ns_s)
      NS_INC: begin
        next_upc_s = inc_s;
      end
      NS_JMP: begin
        next_upc_s = cr_s;
      end
      NS_CJMP: begin
        if (cond_s) begin
          next_upc_s = cr_s;
        end else begin
          next_upc_s = inc_s;
        end
      end
      NS_DISP: begin
        next_upc_s = disp_addr;
      end
      NS_CALL: begin
        // The jump is taken even when the return address cannot be saved.
        next_upc_s = cr_s;
        if (sp_r != SP_FULL) begin
          push_s = 1'b1;
        end else begin
          err_set_s = 1'b1;
        end
      end
      NS_RET: begin
        if (sp_r != SP_ZERO) begin
          next_upc_s = stack_r[0];
          pop_s      = 1'b1;
        end else begin
          next_upc_s = FETCH_A;
          err_set_s  = 1'b1;
        end
      end
      NS_CRET: begin
        if (!cond_s) begin
          next_upc_s = inc_s;
        end else if (sp_r != SP_ZERO) begin
          next_upc_s = stack_r[0];
          pop_s      = 1'b1;
        end else begin
          next_upc_s = FETCH_A;
          err_set_s  = 1'b1;
        end
      end
      NS_FETCH: begin
        next_upc_s = FETCH_A;
      end
      default: begin
        next_upc_s = inc_s;
      end
    endcase
  end

  // uPC, control word pipeline register, stack pointer and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_r     <= RST_A;
      cw_r      <= '0;
      sp_r      <= SP_ZERO;
      stk_err_r <= 1'b0;
    end else if (stall) begin
      // Bubble: datapath sees an all-zero (no side effect) control word.
      cw_r <= '0;
    end else begin
      upc_r <= next_upc_s;
      cw_r  <= rom_data;
      if (push_s) begin
        sp_r <= sp_r + SP_ONE;
      end else if (pop_s) begin
        sp_r <= sp_r - SP_ONE;
      end
      if (err_set_s) begin
        stk_err_r <= 1'b1;
      end
    end
  end

  // Microstack storage: push shifts down, pop shifts up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STK_D; i++) begin
        stack_r[i] <= '0;
      end
    end else if (!stall && push_s) begin
      for (int i = STK_D - 1; i > 0; i--) begin
        stack_r[i] <= stack_r[i-1];
      end
      stack_r[0] <= inc_s;
    end else if (!stall && pop_s) begin
      for (int i = 0; i < STK_D - 1; i++) begin
        stack_r[i] <= stack_r[i+1];
      end
    end
  end

  assign rom_addr = upc_r;
  assign upc_out  = upc_r;
  assign cw_out   = cw_r;
  assign stk_err  = stk_err_r;

endmodule

// File: tb/tb_microseq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_microseq_ctrl
//   Self-checking bench for microseq_ctrl with default parameters. A small
//   microprogram in a bench-owned control store walks through every NS mode,
//   nested calls, stack overflow/underflow, stall bubbles and async reset.
//   Expected uPC / control word / error flag are queued before each clock
//   edge and popped and compared one time unit after it.
// -----------------------------------------------------------------------------
module tb_microseq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [63:0] rom_data;
  logic [7:0]  disp_addr;
  logic [7:0]  cond_in;
  logic        stall;
  logic [63:0] cw_out;
  logic [7:0]  upc_out;
  logic        stk_err;

  logic [63:0] rom [0:255];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  microseq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .disp_addr (disp_addr),
    .cond_in   (cond_in),
    .stall     (stall),
    .cw_out    (cw_out),
    .upc_out   (upc_out),
    .stk_err   (stk_err)
  );

  typedef struct packed {
    logic [7:0]  upc;
    logic [63:0] cw;
    logic        err;
  } exp_t;

  exp_t       sb_q [$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] cur_pc;

  localparam logic [2:0] INC = 3'd0, JMP = 3'd1, CJMP = 3'd2, DISP = 3'd3,
                         CALL = 3'd4, RET = 3'd5, CRET = 3'd6, FETCH = 3'd7;

  function automatic logic [63:0] mw(input logic [2:0] ns, input logic inv,
                                     input logic [2:0] cs, input logic [7:0] cr,
                                     input logic [7:0] tag);
    return {ns, inv, cs, 8'hA5, 33'd0, tag, cr};
  endfunction

  task automatic put(input logic [7:0] addr, input logic [2:0] ns,
                     input logic inv, input logic [2:0] cs, input logic [7:0] cr);
    rom[addr] = mw(ns, inv, cs, cr, addr);
  endtask

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_upc"}, {56'd0, upc_out}, 64'd0);
    check_val({tag, "_cw"}, cw_out, 64'd0);
    check_val({tag, "_err"}, {63'd0, stk_err}, 64'd0);
  endtask

  // Queue the expected outcome of the next edge, then compare after it.
  task automatic step(input logic [7:0] exp_next, input logic exp_err);
    exp_t e;
    e.upc = exp_next;
    e.cw  = stall ? 64'd0 : rom[cur_pc];
    e.err = exp_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_val("upc", {56'd0, upc_out}, {56'd0, e.upc});
      check_val("rom_addr", {56'd0, rom_addr}, {56'd0, e.upc});
      check_val("cw", cw_out, e.cw);
      check_val("stk_err", {63'd0, stk_err}, {63'd0, e.err});
    end
    cur_pc = exp_next;
  endtask

  initial begin
    reset     = 1'b1;
    stall     = 1'b0;
    cond_in   = 8'h00;
    disp_addr = 8'h00;
    for (int i = 0; i < 256; i++) begin
      rom[i] = mw(INC, 1'b0, 3'd0, 8'h00, 8'(i));
    end
    // Program image
    put(8'h01, JMP,  1'b0, 3'd0, 8'h40);
    put(8'h40, CJMP, 1'b0, 3'd4, 8'h20);
    put(8'h20, CJMP, 1'b0, 3'd4, 8'h60);
    put(8'h21, CJMP, 1'b1, 3'd4, 8'h50);
    put(8'h22, CJMP, 1'b1, 3'd4, 8'h44);
    put(8'h44, DISP, 1'b0, 3'd0, 8'h00);
    put(8'h2A, FETCH, 1'b0, 3'd0, 8'h00);
    put(8'h10, CALL, 1'b0, 3'd0, 8'h30);
    put(8'h30, RET,  1'b0, 3'd0, 8'h00);
    put(8'h11, CALL, 1'b0, 3'd0, 8'h70);
    put(8'h70, CALL, 1'b0, 3'd0, 8'h74);
    put(8'h74, CALL, 1'b0, 3'd0, 8'h78);
    put(8'h78, CALL, 1'b0, 3'd0, 8'h7C);
    put(8'h7C, RET,  1'b0, 3'd0, 8'h00);
    put(8'h79, CRET, 1'b0, 3'd4, 8'h00);
    put(8'h75, CRET, 1'b0, 3'd4, 8'h00);
    put(8'h76, RET,  1'b0, 3'd0, 8'h00);
    put(8'h71, RET,  1'b0, 3'd0, 8'h00);
    put(8'h12, CALL, 1'b0, 3'd0, 8'h80);
    put(8'h80, CALL, 1'b0, 3'd0, 8'h84);
    put(8'h84, CALL, 1'b0, 3'd0, 8'h88);
    put(8'h88, CALL, 1'b0, 3'd0, 8'h8C);
    put(8'h8C, CALL, 1'b0, 3'd0, 8'h90);
    put(8'h90, RET,  1'b0, 3'd0, 8'h00);
    put(8'h89, RET,  1'b0, 3'd0, 8'h00);
    put(8'h85, RET,  1'b0, 3'd0, 8'h00);
    put(8'h81, RET,  1'b0, 3'd0, 8'h00);
    put(8'h13, RET,  1'b0, 3'd0, 8'h00);
    put(8'hA0, CALL, 1'b0, 3'd0, 8'hB0);
    put(8'hB0, RET,  1'b0, 3'd0, 8'h00);
    put(8'hA1, RET,  1'b0, 3'd0, 8'h00);
    cur_pc = 8'h00;

    // Reset state, held across an edge
    #1;
    check_reset("rst0");
    @(posedge clk);
    #1;
    check_reset("rst_hold");
    reset = 1'b0;

    // INC from RESET_ADDR, then JMP
    step(8'h01, 1'b0);
    step(8'h40, 1'b0);

    // Async reset mid-run takes effect without a clock edge
    #2;
    reset = 1'b1;
    #1;
    check_reset("rst_mid");
    sb_q.delete();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    cur_pc = 8'h00;
    step(8'h01, 1'b0);
    step(8'h40, 1'b0);

    // Conditional jump, both polarities of INV
    cond_in = 8'h10; step(8'h20, 1'b0);
    cond_in = 8'hEF; step(8'h21, 1'b0);
    cond_in = 8'h10; step(8'h22, 1'b0);
    cond_in = 8'hEF; step(8'h44, 1'b0);

    // Dispatch, fetch, wrap of increment
    disp_addr = 8'h2A;
    step(8'h2A, 1'b0);
    put(8'h01, JMP, 1'b0, 3'd0, 8'hFF);
    put(8'h00, JMP, 1'b0, 3'd0, 8'h10);
    step(8'h01, 1'b0);
    step(8'hFF, 1'b0);
    step(8'h00, 1'b0);
    step(8'h10, 1'b0);

    // Call/return, then 4 nested calls unwinding in order
    step(8'h30, 1'b0);
    step(8'h11, 1'b0);
    step(8'h70, 1'b0);
    step(8'h74, 1'b0);
    step(8'h78, 1'b0);
    step(8'h7C, 1'b0);
    step(8'h79, 1'b0);
    cond_in = 8'h10; step(8'h75, 1'b0);
    cond_in = 8'hEF; step(8'h76, 1'b0);
    step(8'h71, 1'b0);
    step(8'h12, 1'b0);

    // Overflow on 5th call, sticky error, underflow to FETCH_ADDR
    step(8'h80, 1'b0);
    step(8'h84, 1'b0);
    step(8'h88, 1'b0);
    step(8'h8C, 1'b0);
    step(8'h90, 1'b1);
    step(8'h89, 1'b1);
    step(8'h85, 1'b1);
    step(8'h81, 1'b1);
    step(8'h13, 1'b1);
    put(8'h01, JMP, 1'b0, 3'd0, 8'hA0);
    step(8'h01, 1'b1);
    step(8'hA0, 1'b1);

    // Stall on a CALL word: frozen, bubbles, then exactly one push
    stall = 1'b1;
    step(8'hA0, 1'b1);
    step(8'hA0, 1'b1);
    step(8'hA0, 1'b1);
    stall = 1'b0;
    step(8'hB0, 1'b1);
    step(8'hA1, 1'b1);
    step(8'h01, 1'b1);

    // Reset during stall clears the sticky error
    stall = 1'b1;
    step(8'h01, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_reset("rst_stall");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
